// File: rtl/matrix_pkg.sv
// Shared constants and types for the matrix loader and dot-product engine.
// Holds store depths, element/address widths, loader states and store selects.
package matrix_pkg;

    localparam int A_DEPTH    = 4096;
    localparam int B_DEPTH    = 64;
    localparam int DATA_WIDTH = 8;
    localparam int ADDR_W     = $clog2(A_DEPTH);
    localparam int CNT_W      = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        FLUSH,
        DONE
    } loader_state_t;

    localparam logic WR_SEL_A = 1'b0;
    localparam logic WR_SEL_B = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports: clock, reset (sync, active-high), clr, en -> count.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] cnt_q;

    // A clear that coincides with en counts its own cycle, so the
    // clearing cycle is included in the measured interval.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= {{(W-1){1'b0}}, en};
        end else if (en && (cnt_q != '1)) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/matrix_loader.sv
// Streams bytes into the A store then the B store and flags residency.
// Ports: start/in_* stream in; wr_* RAM write port; busy/done/cycle_count/checksum status.
// Optional: LOADER_CHECKSUM_EN builds the 16-bit running checksum.
module matrix_loader
    import matrix_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  wr_en,
    output logic                  wr_sel,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      cycle_count,
    output logic [CNT_W-1:0]      checksum
);

    localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(A_DEPTH - 1);
    localparam logic [ADDR_W-1:0] B_LAST = ADDR_W'(B_DEPTH - 1);

    loader_state_t         state_q;
    logic [ADDR_W-1:0]     idx_q;
    logic                  wr_en_q;
    logic                  wr_sel_q;
    logic [ADDR_W-1:0]     wr_addr_q;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  beat;
    logic                  start_ok;

    assign in_ready = (state_q == LOAD_A) || (state_q == LOAD_B);
    assign beat     = in_valid && in_ready;
    assign start_ok = start && ((state_q == IDLE) || (state_q == DONE));

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_sel_q  <= WR_SEL_A;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            wr_en_q <= beat;
            if (beat) begin
                wr_sel_q  <= (state_q == LOAD_B) ? WR_SEL_B : WR_SEL_A;
                wr_addr_q <= idx_q;
                wr_data_q <= in_data;
            end
            unique case (state_q)
                IDLE, DONE: begin
                    if (start_ok) begin
                        state_q <= LOAD_A;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                LOAD_A: begin
                    if (beat) begin
                        if (idx_q == A_LAST) begin
                            idx_q   <= '0;
                            state_q <= LOAD_B;
                        end else begin
                            idx_q <= idx_q + ADDR_W'(1);
                        end
                    end
                end
                LOAD_B: begin
                    if (beat) begin
                        if (idx_q == B_LAST) begin
                            idx_q   <= '0;
                            state_q <= FLUSH;
                        end else begin
                            idx_q <= idx_q + ADDR_W'(1);
                        end
                    end
                end
                // Gives the final B write a cycle to commit before done.
                FLUSH: begin
                    state_q <= DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_cycles (
        .clock(clock),
        .reset(reset),
        .clr  (start_ok),
        .en   (start_ok || busy_q),
        .count(cycle_count)
    );

`ifdef LOADER_CHECKSUM_EN
    logic [CNT_W-1:0] csum_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            csum_q <= '0;
        end else if (start_ok) begin
            csum_q <= '0;
        end else if (beat) begin
            csum_q <= csum_q + CNT_W'(in_data);
        end
    end

    assign checksum = csum_q;
`else
    assign checksum = '0;
`endif

    assign wr_en   = wr_en_q;
    assign wr_sel  = wr_sel_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_matrix_loader.sv
// Randomized self-checking bench for matrix_loader.
// Compares every cycle against a beat-count reference model.
module tb_matrix_loader;
    import matrix_pkg::*;

    localparam int TOTAL = A_DEPTH + B_DEPTH;

    logic                  clock = 1'b0;
    logic                  reset;
    logic                  start;
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  wr_en;
    logic                  wr_sel;
    logic [ADDR_W-1:0]     wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  busy;
    logic                  done;
    logic [15:0]           cycle_count;
    logic [15:0]           checksum;

    matrix_loader dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .wr_en      (wr_en),
        .wr_sel     (wr_sel),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
        .cycle_count(cycle_count),
        .checksum   (checksum)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_err = 0;
    int pulses = 0;

    logic [7:0] src [TOTAL];

    bit         m_busy, m_done, m_wv, m_wsel;
    int         m_beats, m_cnt, m_sum, m_waddr;
    logic [7:0] m_wdata;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_sum();
`ifdef LOADER_CHECKSUM_EN
        return 16'(m_sum);
`else
        return 16'h0000;
`endif
    endfunction

    function automatic int src_sum();
        int s = 0;
        for (int i = 0; i < TOTAL; i++) s += int'(src[i]);
        return s % 65536;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_done = 0; m_beats = 0; m_cnt = 0; m_sum = 0;
        m_wv = 0; m_wsel = 0; m_waddr = 0; m_wdata = 0;
    endtask

    task automatic model_step(input bit r, input bit s, input bit v,
                              input logic [7:0] d);
        bit acc;
        if (r) begin
            model_reset();
            return;
        end
        acc = v && m_busy && (m_beats < TOTAL);
        m_wv = acc;
        if (acc) begin
            m_wsel  = (m_beats >= A_DEPTH);
            m_waddr = m_wsel ? m_beats - A_DEPTH : m_beats;
            m_wdata = d;
        end
        if (!m_busy && s) begin
            m_busy = 1; m_done = 0; m_beats = 0; m_cnt = 1; m_sum = 0;
        end else if (m_busy) begin
            m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
            if (m_beats == TOTAL) begin
                m_busy = 0;
                m_done = 1;
            end
            if (acc) begin
                m_beats++;
                m_sum = (m_sum + int'(d)) % 65536;
            end
        end
    endtask

    task automatic check_outputs();
        bit exp_rdy;
        exp_rdy = m_busy && (m_beats < TOTAL);
        if (wr_en === 1'b1) pulses++;
        chk("ctl", 64'({in_ready, busy, done, wr_en}),
            64'({exp_rdy, m_busy, m_done, m_wv}));
        if (wr_en === 1'b1 || m_wv)
            chk("wr", 64'({wr_sel, wr_addr, wr_data}),
                64'({m_wsel, ADDR_W'(m_waddr), m_wdata}));
        chk("stat", 64'({cycle_count, checksum}),
            64'({16'(m_cnt), exp_sum()}));
    endtask

    task automatic cyc(input bit r, input bit s, input bit v);
        logic [7:0] d;
        d = (m_beats < TOTAL) ? src[m_beats] : 8'($urandom);
        reset = r; start = s; in_valid = v; in_data = d;
        @(negedge clock);
        check_outputs();
        @(posedge clock);
        model_step(r, s, v, d);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, 64'({in_ready, wr_en, wr_sel, wr_addr, wr_data,
                      busy, done, cycle_count, checksum}), 64'd0);
    endtask

    // mode 0: streaming, 1: toggling (low first), 2: random stalls
    task automatic run_load(input int mode, input int st_inj,
                            input int rs_inj);
        int k;
        bit v, s, r, st_used;
        st_used = 0;
        cyc(0, 1, 0);
        k = 0;
        while (!m_done) begin
            if (k > 20000) begin
                chk("timeout", 64'(done), 64'd1);
                return;
            end
            case (mode)
                0: v = 1;
                1: v = k[0];
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            s = (st_inj >= 0) && (m_beats == st_inj) && !st_used;
            if (s) begin
                st_used = 1;
                v = 1;
            end
            r = (rs_inj >= 0) && (m_beats == rs_inj);
            cyc(r, s, v);
            k++;
            if (r) return;
        end
    endtask

    initial begin
        reset = 1; start = 0; in_valid = 0; in_data = 0;
        repeat (2) @(posedge clock);
        model_reset();
        #1;
        cyc(1, 0, 1);
        for (int i = 0; i < 5; i++) cyc(0, 0, 1);
        chk_all_zero("idle");

        for (int i = 0; i < TOTAL; i++)
            src[i] = (i < A_DEPTH) ? 8'(i) : 8'(i - A_DEPTH + 1);
        pulses = 0;
        run_load(0, -1, -1);
        chk("pulses", 64'(pulses), 64'(TOTAL));
        chk("cnt_stream", 64'(cycle_count), 64'd4162);
        chk("sum_stream", 64'(checksum), 64'(exp_sum()));
`ifdef LOADER_CHECKSUM_EN
        chk("sum_value", 64'(checksum), 64'(src_sum()));
`endif
        cyc(0, 0, 1);
        cyc(0, 0, 0);

        pulses = 0;
        run_load(1, -1, -1);
        chk("pulses_stall", 64'(pulses), 64'(TOTAL));
        chk("cnt_stall", 64'(cycle_count), 64'd8322);

        for (int i = 0; i < TOTAL; i++) src[i] = 8'($urandom);
        run_load(0, 100, -1);
        chk("inj_start_done", 64'(done), 64'd1);

        run_load(2, -1, A_DEPTH + 10);
        chk_all_zero("rst_mid");
        cyc(0, 0, 1);
        run_load(2, -1, -1);
        chk("reload_done", 64'(done), 64'd1);

        for (int i = 0; i < TOTAL; i++)
            src[i] = (i < A_DEPTH) ? 8'(i) : 8'(i - A_DEPTH + 1);
        run_load(0, -1, -1);
        chk("cnt_reload", 64'(cycle_count), 64'd4162);
`ifdef LOADER_CHECKSUM_EN
        chk("sum_reload", 64'(checksum), 64'(src_sum()));
`else
        chk("sum_off", 64'(checksum), 64'd0);
`endif
        cyc(0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
